// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler: round-robin owner of the HD44780 pins, generating EN setup/pulse/hold and execution delays.
module lcd_bus_scheduler #(
    parameter int T_POWERUP   = 750000,
    parameter int T_SETUP     = 2,
    parameter int T_EN_HIGH   = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int CNT_W       = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_req,
    input  logic       i_cmd_rs,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_ack,
    input  logic       i_txt_req,
    input  logic       i_txt_rs,
    input  logic [7:0] i_txt_data,
    output logic       o_txt_ack,
    output logic       o_busy,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic [7:0] o_lcd_data
);
    typedef enum logic [2:0] {S_POWERUP, S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_EXEC} state_t;

    localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;

    if (T_POWERUP < 1 || T_SETUP < 1 || T_EN_HIGH < 1 || T_HOLD < 1 || T_EXEC < 1 || T_EXEC_LONG < 1 ||
        T_POWERUP - 1 > MAX_CNT || T_SETUP - 1 > MAX_CNT || T_EN_HIGH - 1 > MAX_CNT ||
        T_HOLD - 1 > MAX_CNT || T_EXEC - 1 > MAX_CNT || T_EXEC_LONG - 1 > MAX_CNT) begin : g_param_err
        $error("lcd_bus_scheduler: timing parameter out of range for CNT_W");
    end

    state_t             r_state, w_state_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n, w_exec_load;
    logic               r_rs, w_rs_n;
    logic [7:0]         r_data, w_data_n;
    logic               r_en, r_busy, r_cmd_ack, r_txt_ack, w_cmd_ack_n, w_txt_ack_n;
    logic               r_last_txt, w_last_txt_n;
    logic               w_cnt_zero, w_grant_cmd, w_long;

    assign w_cnt_zero  = r_cnt == '0;
    // On a tie, the port that did not win last time gets the bus
    assign w_grant_cmd = i_cmd_req && (!i_txt_req || r_last_txt);
    // Clear (0x01) and return-home (0x02/0x03) need the long execution time
    assign w_long      = !r_rs && r_data[7:2] == 6'd0 && r_data[1:0] != 2'd0;
    assign w_exec_load = w_long ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
        w_rs_n       = r_rs;
        w_data_n     = r_data;
        w_last_txt_n = r_last_txt;
        w_cmd_ack_n  = 1'b0;
        w_txt_ack_n  = 1'b0;
        unique case (r_state)
            S_POWERUP: w_state_n = w_cnt_zero ? S_IDLE : S_POWERUP;
            S_IDLE: if (i_cmd_req || i_txt_req) begin
                w_state_n    = S_SETUP;
                w_cnt_n      = CNT_W'(T_SETUP - 1);
                w_rs_n       = w_grant_cmd ? i_cmd_rs : i_txt_rs;
                w_data_n     = w_grant_cmd ? i_cmd_data : i_txt_data;
                w_last_txt_n = !w_grant_cmd;
                w_cmd_ack_n  = w_grant_cmd;
                w_txt_ack_n  = !w_grant_cmd;
            end
            S_SETUP: if (w_cnt_zero) begin
                w_state_n = S_ENABLE;
                w_cnt_n   = CNT_W'(T_EN_HIGH - 1);
            end
            S_ENABLE: if (w_cnt_zero) begin
                w_state_n = S_HOLD;
                w_cnt_n   = CNT_W'(T_HOLD - 1);
            end
            S_HOLD: if (w_cnt_zero) begin
                w_state_n = S_EXEC;
                w_cnt_n   = w_exec_load;
            end
            S_EXEC: w_state_n = w_cnt_zero ? S_IDLE : S_EXEC;
            default: w_state_n = S_POWERUP;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_POWERUP;
            r_cnt      <= CNT_W'(T_POWERUP - 1);
            r_rs       <= 1'b0;
            r_data     <= 8'd0;
            r_en       <= 1'b0;
            r_busy     <= 1'b1;
            r_cmd_ack  <= 1'b0;
            r_txt_ack  <= 1'b0;
            r_last_txt <= 1'b1;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_rs       <= w_rs_n;
            r_data     <= w_data_n;
            r_en       <= w_state_n == S_ENABLE;
            r_busy     <= w_state_n != S_IDLE;
            r_cmd_ack  <= w_cmd_ack_n;
            r_txt_ack  <= w_txt_ack_n;
            r_last_txt <= w_last_txt_n;
        end
    end

    assign o_cmd_ack  = r_cmd_ack;
    assign o_txt_ack  = r_txt_ack;
    assign o_busy     = r_busy;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = r_en;
    assign o_lcd_data = r_data;
endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb_lcd_bus_scheduler: directed bench with a timeline model of the LCD bus scheduler.
module tb_lcd_bus_scheduler;
    localparam int TP = 10, TS = 2, TE = 3, TH = 1, TX = 5, TL = 20;

    logic       clk = 1'b0, rst = 1'b1;
    logic       cmd_req = 1'b0, cmd_rs = 1'b0, txt_req = 1'b0, txt_rs = 1'b0;
    logic [7:0] cmd_data = 8'd0, txt_data = 8'd0;
    logic       cmd_ack, txt_ack, busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_bus_scheduler #(
        .T_POWERUP(TP), .T_SETUP(TS), .T_EN_HIGH(TE), .T_HOLD(TH),
        .T_EXEC(TX), .T_EXEC_LONG(TL), .CNT_W(20)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_req(cmd_req), .i_cmd_rs(cmd_rs), .i_cmd_data(cmd_data), .o_cmd_ack(cmd_ack),
        .i_txt_req(txt_req), .i_txt_rs(txt_rs), .i_txt_data(txt_data), .o_txt_ack(txt_ack),
        .o_busy(busy), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en), .o_lcd_data(lcd_data)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: a transfer captured at edge `cap` occupies the bus for a fixed
    // number of edges; the bus is grantable on any edge after `idle_from`.
    int         n = 0, idle_from = 0, cap = -1000;
    bit         cap_cmd = 1'b0, m_last_txt = 1'b1, started = 1'b0;
    logic       m_rs = 1'b0;
    logic [7:0] m_data = 8'd0;

    always @(posedge clk) begin
        n++;
        if (rst) begin
            idle_from  = n + TP;
            cap        = -1000;
            m_rs       = 1'b0;
            m_data     = 8'd0;
            m_last_txt = 1'b1;
        end else if (n > idle_from && (cmd_req || txt_req)) begin
            if (cmd_req && txt_req) cap_cmd = m_last_txt;
            else cap_cmd = cmd_req;
            m_last_txt = !cap_cmd;
            m_rs       = cap_cmd ? cmd_rs : txt_rs;
            m_data     = cap_cmd ? cmd_data : txt_data;
            cap        = n;
            idle_from  = n + TS + TE + TH + ((!m_rs && m_data inside {8'h01, 8'h02, 8'h03}) ? TL : TX);
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", busy, n < idle_from);
            chk("lcd_en", lcd_en, (n - cap) >= TS && (n - cap) < TS + TE);
            chk("cmd_ack", cmd_ack, n == cap && cap_cmd);
            chk("txt_ack", txt_ack, n == cap && !cap_cmd);
            chk("lcd_rs", lcd_rs, m_rs);
            chk("lcd_data", lcd_data, m_data);
            chk("lcd_rw", lcd_rw, 1'b0);
        end
    end

    task automatic wait_ack(input bit is_cmd, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(is_cmd ? cmd_ack : txt_ack) && k < 200);
    endtask

    task automatic wait_idle(output int m, output int first_en, output int en_cnt);
        m = 0; first_en = -1; en_cnt = 0;
        do begin
            @(negedge clk);
            m++;
            if (lcd_en) begin
                en_cnt++;
                if (first_en < 0) first_en = m;
            end
        end while (busy && m < 200);
    endtask

    task automatic wait_en();
        for (int i = 0; i < 200 && !lcd_en; i++) @(negedge clk);
    endtask

    task automatic run_xfer(input bit is_cmd, input logic rs, input logic [7:0] data,
                            input int exp_idle, input string name);
        int k, m, fe, ec;
        if (is_cmd) begin cmd_req = 1'b1; cmd_rs = rs; cmd_data = data; end
        else begin txt_req = 1'b1; txt_rs = rs; txt_data = data; end
        wait_ack(is_cmd, k);
        chk({name, "_ack_latency"}, k, 1);
        cmd_req = 1'b0;
        txt_req = 1'b0;
        chk({name, "_rs"}, lcd_rs, rs);
        chk({name, "_data"}, lcd_data, data);
        wait_idle(m, fe, ec);
        chk({name, "_idle_after"}, m, exp_idle);
        chk({name, "_en_rise"}, fe, 2);
        chk({name, "_en_width"}, ec, 3);
    endtask

    initial begin
        int k, m, fe, ec, g, pre_en;
        bit seq[4];
        bit cmd_re, txt_re;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b1);
        chk("reset_en", lcd_en, 1'b0);
        chk("reset_data", lcd_data, 8'h00);
        rst = 1'b0;
        // Power-up hold-off: request raised one cycle after release
        k = 0; pre_en = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin cmd_req = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h38; end
            if (lcd_en) pre_en++;
        end while (!cmd_ack && k < 200);
        chk("powerup_ack_cycle", k, 11);
        chk("powerup_en_before_ack", pre_en, 0);
        cmd_req = 1'b0;
        wait_idle(m, fe, ec);
        chk("powerup_xfer_idle", m, 11);

        run_xfer(1'b0, 1'b1, 8'h41, 11, "txt_A");
        run_xfer(1'b1, 1'b0, 8'h01, 26, "clear");
        run_xfer(1'b1, 1'b0, 8'h02, 26, "home");
        run_xfer(1'b1, 1'b0, 8'h04, 11, "entry_mode");
        run_xfer(1'b1, 1'b1, 8'h01, 11, "data_01");

        // Payload freeze
        txt_req = 1'b1; txt_rs = 1'b1; txt_data = 8'h30;
        wait_ack(1'b0, k);
        chk("freeze_ack_latency", k, 1);
        txt_req = 1'b0;
        wait_en();
        txt_data = 8'h31;
        m = 0;
        do begin
            @(negedge clk);
            m++;
            chk("freeze_data", lcd_data, 8'h30);
        end while (busy && m < 200);
        chk("freeze_idle_data", lcd_data, 8'h30);

        // Round robin with both requesters continuously active
        cmd_req = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h61;
        txt_req = 1'b1; txt_rs = 1'b1; txt_data = 8'h62;
        g = 0; cmd_re = 1'b0; txt_re = 1'b0;
        for (int t = 0; t < 400 && g < 4; t++) begin
            @(negedge clk);
            if (cmd_re) begin cmd_req = 1'b1; cmd_re = 1'b0; end
            if (txt_re) begin txt_req = 1'b1; txt_re = 1'b0; end
            if (cmd_ack) begin seq[g] = 1'b1; g++; cmd_req = 1'b0; cmd_re = 1'b1; end
            if (txt_ack) begin seq[g] = 1'b0; g++; txt_req = 1'b0; txt_re = 1'b1; end
        end
        cmd_req = 1'b0; txt_req = 1'b0;
        chk("rr_grants", g, 4);
        chk("rr_seq0_cmd", seq[0], 1'b1);
        chk("rr_seq1_txt", seq[1], 1'b0);
        chk("rr_seq2_cmd", seq[2], 1'b1);
        chk("rr_seq3_txt", seq[3], 1'b0);
        wait_idle(m, fe, ec);
        chk("rr_final_idle", busy, 1'b0);

        // Reset while EN is high
        cmd_req = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h55;
        wait_ack(1'b1, k);
        cmd_req = 1'b0;
        wait_en();
        chk("midreset_en_before", lcd_en, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_en", lcd_en, 1'b0);
        chk("midreset_busy", busy, 1'b1);
        chk("midreset_cmd_ack", cmd_ack, 1'b0);
        chk("midreset_data", lcd_data, 8'h00);
        rst = 1'b0;
        cmd_req = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h0C;
        wait_ack(1'b1, k);
        chk("midreset_regrant_cycle", k, 11);
        cmd_req = 1'b0;
        wait_idle(m, fe, ec);
        chk("midreset_xfer_idle", m, 11);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_bus_scheduler.md
Name: lcd_bus_scheduler

Overview:
- Owns the HD44780-style LCD pins (LCD_RS/LCD_RW/LCD_EN/LCD_DATA) and shares them between two requesters:
  - the command/init sequencer (cmd port);
  - the text/CRC writer (txt port).
- Arbitrates per transfer with round-robin and generates EN pulse timing with setup, hold and execution-delay counters.
- Selects the long execution delay for clear/home commands, and holds off all traffic for a power-up interval after reset.
- Sits between the LCD writer FSMs and the top-level pins.

Parameters:
- T_POWERUP, 750000, cycles after reset before first grant (15 ms at 50 MHz)
- T_SETUP, 2, cycles RS/DATA valid before EN rises (>=1)
- T_EN_HIGH, 12, cycles EN held high (>=1)
- T_HOLD, 2, cycles RS/DATA held after EN falls (>=1)
- T_EXEC, 2000, post-transfer wait for normal command/data (40 us)
- T_EXEC_LONG, 82000, post-transfer wait for clear/home (1.64 ms)
- CNT_W, 20, delay counter width; must hold max(T_*)

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- cmd_req  in  1  cmd requester wants a transfer; held until cmd_ack
- cmd_rs  in  1  RS value for cmd transfer (0 = instruction, 1 = data)
- cmd_data  in  8  byte for cmd transfer
- cmd_ack  out  1  one-cycle pulse: cmd payload captured
- txt_req  in  1  txt requester wants a transfer; held until txt_ack
- txt_rs  in  1  RS value for txt transfer
- txt_data  in  8  byte for txt transfer
- txt_ack  out  1  one-cycle pulse: txt payload captured
- busy  out  1  high in every state except IDLE
- LCD_RS  out  1  LCD register select
- LCD_RW  out  1  LCD read/write; constant 0 (write-only)
- LCD_EN  out  1  LCD enable strobe
- LCD_DATA  out  8  LCD data bus

Behaviour:
- All outputs are registered.
- Reset values:
  - state = POWERUP; counter = T_POWERUP-1;
  - LCD_RS = LCD_RW = LCD_EN = 0; LCD_DATA = 0;
  - cmd_ack = txt_ack = 0; busy = 1 (POWERUP counts as busy);
  - last_grant = TXT, so cmd wins the first tie.
- Reset mid-transfer:
  - on the next edge, EN = 0 and the captured payload is dropped;
  - no ack is issued; the power-up wait restarts.
- States:
  - POWERUP: count down; at 0 go to IDLE. Requests are ignored; no ack.
  - IDLE: busy = 0. If any req is high, grant per arbitration, capture rs/data into LCD_RS/LCD_DATA, load counter = T_SETUP-1, go to SETUP.
  - SETUP: EN = 0; at counter 0 load T_EN_HIGH-1, go to ENABLE.
  - ENABLE: EN = 1; at counter 0 load T_HOLD-1, go to HOLD. EN falls on that edge.
  - HOLD: EN = 0, RS/DATA unchanged; at counter 0 load the exec delay minus 1, go to EXEC.
  - EXEC: EN = 0, RS/DATA unchanged; at counter 0 go to IDLE.
- Exec delay selection:
  - T_EXEC_LONG when captured rs = 0 and data[7:2] = 0 and data[1:0] != 0 (clear 0x01, home 0x02/0x03);
  - otherwise T_EXEC.
- Ack timing:
  - the granted ack is high for exactly the first SETUP cycle (registered at the capture edge);
  - the requester drops or advances req after seeing ack;
  - req is not sampled outside IDLE, so a req held into the following IDLE cycle starts a new transfer. Requesters must deassert in the ack cycle.
- Arbitration, evaluated only in IDLE:
  - only one req high: grant it;
  - both high: grant the one not equal to last_grant;
  - last_grant updates on each capture.
- Latency:
  - req high in IDLE -> capture on that edge;
  - EN rises T_SETUP cycles after capture and stays high T_EN_HIGH cycles;
  - IDLE is re-entered T_SETUP+T_EN_HIGH+T_HOLD+exec cycles after capture;
  - a back-to-back transfer can be captured in that IDLE cycle.
- The payload is frozen after capture; changes on cmd_*/txt_* during a transfer have no effect.
- LCD_DATA/LCD_RS retain their last value in IDLE.
- Counter underflow is impossible: every load is <= 2^CNT_W-1. Values above that are a parameter error, caught by an elaboration check.

Test Plan (sim params: T_POWERUP=10, T_SETUP=2, T_EN_HIGH=3, T_HOLD=1, T_EXEC=5, T_EXEC_LONG=20):
- Power-up hold-off: assert cmd_req (rs=0, data=0x38) at cycle 1 after Reset falls -> no ack and EN=0 for 10 cycles, then cmd_ack pulses once.
- Single data write: txt_req with rs=1, data=0x41 ('A') in IDLE:
  - txt_ack high for 1 cycle; LCD_RS=1, LCD_DATA=0x41;
  - EN high exactly cycles 3-5 after capture;
  - busy low again 11 cycles after capture.
- Long delay: cmd rs=0, data=0x01 -> IDLE 26 cycles after capture. Repeat with data=0x04 -> 11 cycles. Repeat with rs=1, data=0x01 -> 11 cycles.
- Round-robin: cmd_req and txt_req held continuously (each dropped 1 cycle after its ack, then re-raised):
  - grants alternate cmd, txt, cmd, txt;
  - never two consecutive acks to the same port.
- Payload freeze: change txt_data from 0x30 to 0x31 during ENABLE -> LCD_DATA stays 0x30 through HOLD and EXEC.
- Reset mid-ENABLE: assert Reset while EN=1 -> EN=0 on the next edge, busy=1, no ack; a new transfer is granted only after 10 power-up cycles.
